// File: rtl/ws2812_status_seq.sv
// Status-LED colour sequencer for the on-board WS2812 driver.
// It turns the system status inputs into one 24-bit colour word, picking
// the most important status first. The word changes only on a pattern tick.
module ws2812_status_seq #(
   parameter int          CLK_FRE        = 32_000_000,
   parameter int          TICK_HZ        = 50,
   parameter int          BLINK_TICKS    = 10,
   parameter int          ACT_HOLD_TICKS = 5,
   parameter logic [7:0]  BRIGHT         = 8'd32,
   parameter logic [7:0]  FADE_STEP      = 8'd4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ready,
   input  logic        fdd_act,
   input  logic        sd_busy,
   input  logic        error,
   output logic [23:0] color
);

   localparam int DIV    = CLK_FRE / TICK_HZ;
   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HOLD_W = $clog2(ACT_HOLD_TICKS + 1);
   localparam int BLK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(ACT_HOLD_TICKS);
   localparam logic [BLK_W-1:0]  BLINK_LAST = BLK_W'(BLINK_TICKS - 1);

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_IDLE,
      ST_ACT,
      ST_SD,
      ST_ERROR
   } state_e;

   // Synchroniser bit order: {error, sd_busy, fdd_act, ready}
   logic [3:0] meta_q, sync_q;
   logic       ready_s, act_s, sd_s, err_s;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic              blink_on_q, blink_on_d;
   logic [7:0]        level_q, level_d;
   logic              dir_up_q, dir_up_d;
   logic              fresh_q, fresh_d;
   logic [23:0]       color_q, color_d;

   logic              tick;
   logic [8:0]        fade_sum;

   // The first bit out on the wire is color[0], so the {G,R,B} word is bit-reversed.
   function automatic logic [23:0] pack_grb(input logic [7:0] g, input logic [7:0] r,
                                            input logic [7:0] b);
      logic [23:0] grb;
      logic [23:0] rev;
      grb = {g, r, b};
      for (int i = 0; i < 24; i++) begin
         rev[i] = grb[23-i];
      end
      return rev;
   endfunction

   // Two-flop synchronisers; fdd_act in particular may come from another clock domain.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignments make both stages sample at the same edge,
         // so this really is a two-flop chain and not a single wire.
         meta_q <= {error, sd_busy, fdd_act, ready};
         sync_q <= meta_q;
      end
   end

   assign {err_s, sd_s, act_s, ready_s} = sync_q;
   assign tick     = (div_q == DIV_LAST);
   assign fade_sum = {1'b0, level_q} + {1'b0, FADE_STEP};
   assign color    = color_q;

   // State register for the pattern engine.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_BOOT;
         div_q       <= '0;
         hold_q      <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         level_q     <= '0;
         dir_up_q    <= 1'b1;
         fresh_q     <= 1'b1;
         color_q     <= '0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         hold_q      <= hold_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         level_q     <= level_d;
         dir_up_q    <= dir_up_d;
         fresh_q     <= fresh_d;
         color_q     <= color_d;
      end
   end

   // Next-state logic: tick divider, activity stretch, priority select, blink, fade, colour.
   always_comb begin
      // NOTE: every output of this block gets a default first. A path that leaves
      // one unassigned would infer a latch.
      state_d     = state_q;
      div_d       = div_q + DIV_W'(1);
      hold_d      = hold_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      level_d     = level_q;
      dir_up_d    = dir_up_q;
      fresh_d     = fresh_q;
      color_d     = color_q;

      if (tick) begin
         div_d = '0;
      end

      // A load wins over a tick decrement in the same cycle.
      if (act_s) begin
         hold_d = HOLD_LOAD;
      end else if (tick && (hold_q != '0)) begin
         hold_d = hold_q - HOLD_W'(1);
      end

      if (tick) begin
         fresh_d = 1'b0;

         if (err_s) begin
            state_d = ST_ERROR;
         end else if (sd_s) begin
            state_d = ST_SD;
         end else if (hold_q != '0) begin
            state_d = ST_ACT;
         end else if (!ready_s) begin
            state_d = ST_BOOT;
         end else begin
            state_d = ST_IDLE;
         end

         // Blink phase: restart on entry, then toggle every BLINK_TICKS ticks.
         if (state_d == ST_ERROR) begin
            if (state_q != ST_ERROR) begin
               blink_on_d  = 1'b1;
               blink_cnt_d = '0;
            end else if (blink_cnt_q == BLINK_LAST) begin
               blink_on_d  = ~blink_on_q;
               blink_cnt_d = '0;
            end else begin
               blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
         end

         // Breathing: the entry tick (including the first tick after reset) shows level 0.
         if (state_d == ST_BOOT) begin
            if ((state_q != ST_BOOT) || fresh_q) begin
               level_d  = '0;
               dir_up_d = 1'b1;
            end else if (dir_up_q) begin
               if (fade_sum >= {1'b0, BRIGHT}) begin
                  level_d  = BRIGHT;
                  dir_up_d = 1'b0;
               end else begin
                  level_d = fade_sum[7:0];
               end
            end else if (level_q <= FADE_STEP) begin
               level_d  = '0;
               dir_up_d = 1'b1;
            end else begin
               level_d = level_q - FADE_STEP;
            end
         end

         unique case (state_d)
            ST_IDLE:  color_d = pack_grb(BRIGHT >> 2, 8'd0, 8'd0);
            ST_ACT:   color_d = pack_grb(BRIGHT, BRIGHT, 8'd0);
            ST_SD:    color_d = pack_grb(8'd0, 8'd0, BRIGHT);
            ST_ERROR: color_d = blink_on_d ? pack_grb(8'd0, BRIGHT, 8'd0) : 24'd0;
            ST_BOOT:  color_d = pack_grb(8'd0, 8'd0, level_d);
            default:  color_d = 24'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_status_seq.sv
// Self-checking bench for ws2812_status_seq with a 10-clock tick.
// A table of per-tick vectors covers the main patterns. Hand-written sequences
// cover the pulse stretch, stability between ticks and reset in mid-pattern.
module tb_ws2812_status_seq;

   localparam int TICK_CLKS = 10;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ready, fdd_act, sd_busy, error;
   logic [23:0] color;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc;

   typedef struct {
      logic        ready;
      logic        fdd;
      logic        sd;
      logic        err;
      logic [23:0] exp;
   } vec_t;

   vec_t vq[$];

   ws2812_status_seq #(
      .CLK_FRE        (1000),
      .TICK_HZ        (100),
      .BLINK_TICKS    (2),
      .ACT_HOLD_TICKS (3),
      .BRIGHT         (8'd32),
      .FADE_STEP      (8'd10)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .ready   (ready),
      .fdd_act (fdd_act),
      .sd_busy (sd_busy),
      .error   (error),
      .color   (color)
   );

   always #5 clk = ~clk;

   // Bench-side clock count since reset release; the DUT should tick on every tenth edge.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: color=%06h, required %06h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next tick edge.
   task automatic wait_tick();
      do begin
         @(posedge clk);
         #1;
      end while ((cyc % TICK_CLKS) != 0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      resetn  = 1'b0;
      ready   = 1'b0;
      fdd_act = 1'b0;
      sd_busy = 1'b0;
      error   = 1'b0;

      // Per-tick vectors: inputs are applied just after one tick, the colour is checked after the next.
      // Boot breathing: B = 0,10,20,30,32,22,12,2,0,10
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h500000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h280000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h780000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h040000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h680000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h300000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h400000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h500000});
      // Idle dim green
      vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 24'h000010});
      vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 24'h000010});
      // Error and SD together: error wins and blinks 2 on, 2 off
      vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 24'h000400});
      vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 24'h000400});
      vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 24'h000000});
      vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 24'h000000});
      vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 24'h000400});
      vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 24'h000400});
      // Error dropped: SD blue; then back to idle
      vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 24'h040000});
      vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 24'h000010});
      // Activity held for 10 ticks, then 3 stretched ticks, then idle
      for (int i = 0; i < 10; i++) vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 24'h000404});
      for (int i = 0; i < 3; i++)  vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 24'h000404});
      vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 24'h000010});
      // Re-entering boot restarts the fade at level 0
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 24'h500000});

      // Reset state and first-tick latency
      repeat (3) @(posedge clk);
      #1 check("reset_color", color, 24'h000000);
      release_reset();
      repeat (5) @(posedge clk);
      #1 check("pre_tick_5", color, 24'h000000);
      repeat (4) @(posedge clk);
      #1 check("pre_tick_9", color, 24'h000000);

      foreach (vq[i]) begin
         ready   = vq[i].ready;
         fdd_act = vq[i].fdd;
         sd_busy = vq[i].sd;
         error   = vq[i].err;
         wait_tick();
         check($sformatf("vec%0d", i), color, vq[i].exp);
      end

      // Idle is stable between ticks; a one-clock activity pulse stretches to 3 ticks
      ready = 1'b1;
      wait_tick();
      check("idle_entry", color, 24'h000010);
      repeat (5) @(posedge clk);
      #1 check("idle_mid_period", color, 24'h000010);
      fdd_act = 1'b1;
      @(posedge clk);
      #1 fdd_act = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_tick();
         check($sformatf("pulse_act%0d", i), color, 24'h000404);
      end
      wait_tick();
      check("pulse_idle", color, 24'h000010);

      // Reset in mid-blink clears at once; the first tick after release enters error fresh
      error = 1'b1;
      wait_tick();
      check("blink_on", color, 24'h000400);
      @(posedge clk);
      #3 resetn = 1'b0;
      #1 check("blink_async_clear", color, 24'h000000);
      repeat (2) @(posedge clk);
      release_reset();
      repeat (9) @(posedge clk);
      #1 check("blink_post_rst_9", color, 24'h000000);
      wait_tick();
      check("blink_restart", color, 24'h000400);

      // Reset in mid-fade: the fade restarts at level 0 after release
      error = 1'b0;
      ready = 1'b0;
      wait_tick();
      check("boot_from_error", color, 24'h000000);
      wait_tick();
      check("boot_step1", color, 24'h500000);
      @(posedge clk);
      #3 resetn = 1'b0;
      #1 check("fade_async_clear", color, 24'h000000);
      repeat (2) @(posedge clk);
      release_reset();
      repeat (9) @(posedge clk);
      #1 check("fade_post_rst_9", color, 24'h000000);
      wait_tick();
      check("fade_restart0", color, 24'h000000);
      wait_tick();
      check("fade_restart1", color, 24'h500000);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
